// File: rtl/if_stage.sv
// ============================================================================
// if_stage : instruction-fetch stage with fetch PC, IF/ID register, redirect,
//            flush/stall control, sticky misaligned flag and fetch counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] imem_addr_o,
  output logic [31:0] pc_IF,
  output logic [31:0] instr_IF,
  output logic [31:0] pc_ID,
  output logic [31:0] instr_ID,
  output logic        valid_ID,
  output logic        misaligned_o,
  output logic [31:0] fetch_count_o
);

  logic [31:0] pc_if_q,    pc_if_d;
  logic [31:0] pc_id_q,    pc_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic        valid_id_q, valid_id_d;
  logic        mis_q,      mis_d;
  logic [31:0] count_q,    count_d;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = pc_if_q + 32'd4;

  // rstn is active-high despite its name; it only acts on the clock edge.
  always_ff @(posedge clk) begin
    if (rstn) begin
      pc_if_q    <= RESET_PC;
      pc_id_q    <= 32'h0;
      instr_id_q <= NOP;
      valid_id_q <= 1'b0;
      mis_q      <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      pc_if_q    <= pc_if_d;
      pc_id_q    <= pc_id_d;
      instr_id_q <= instr_id_d;
      valid_id_q <= valid_id_d;
      mis_q      <= mis_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    pc_if_d    = pc_if_q;
    pc_id_d    = pc_id_q;
    instr_id_d = instr_id_q;
    valid_id_d = valid_id_q;
    mis_d      = mis_q;
    count_d    = count_q;

    if (redirect_i) begin
      // Redirect wins over stall and flush; target is force-aligned.
      pc_if_d    = {redirect_pc_i[31:2], 2'b00};
      pc_id_d    = pc_if_q;
      instr_id_d = NOP;
      valid_id_d = 1'b0;
      if (redirect_pc_i[1:0] != 2'b00) begin
        mis_d = 1'b1;
      end
    end else if (flush_i) begin
      pc_if_d    = stall_i ? pc_if_q : w_pc_plus4;
      pc_id_d    = pc_if_q;
      instr_id_d = NOP;
      valid_id_d = 1'b0;
    end else if (!stall_i) begin
      pc_if_d    = w_pc_plus4;
      pc_id_d    = pc_if_q;
      instr_id_d = imem_data_i;
      valid_id_d = 1'b1;
      count_d    = count_q + 32'd1;
    end
  end

  assign imem_addr_o   = pc_if_q;
  assign pc_IF         = pc_if_q;
  assign instr_IF      = imem_data_i;
  assign pc_ID         = pc_id_q;
  assign instr_ID      = instr_id_q;
  assign valid_ID      = valid_id_q;
  assign misaligned_o  = mis_q;
  assign fetch_count_o = count_q;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// tb_if_stage : scoreboard bench for if_stage with directed and random traffic.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] PATTERN  = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic [31:0] imem_data_i;
  logic [31:0] imem_addr_o;
  logic [31:0] pc_IF, instr_IF, pc_ID, instr_ID, fetch_count_o;
  logic        valid_ID, misaligned_o;

  if_stage #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_data_i   (imem_data_i),
    .imem_addr_o   (imem_addr_o),
    .pc_IF         (pc_IF),
    .instr_IF      (instr_IF),
    .pc_ID         (pc_ID),
    .instr_ID      (instr_ID),
    .valid_ID      (valid_ID),
    .misaligned_o  (misaligned_o),
    .fetch_count_o (fetch_count_o)
  );

  // Instruction memory: every word is its address XOR a fixed pattern.
  assign imem_data_i = imem_addr_o ^ PATTERN;

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_if;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        valid;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  int   n_compared = 0;
  int   n_failed   = 0;
  int   n_pushed   = 0;
  int   n_popped   = 0;
  bit   done       = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: pipeline state after one clock edge, from the priority rules.
  task automatic step(input bit r, input bit s, input bit f, input bit rd, input logic [31:0] rpc);
    @(negedge clk);
    rstn = r; stall_i = s; flush_i = f; redirect_i = rd; redirect_pc_i = rpc;
    if (r) begin
      m.pc_if = RESET_PC; m.pc_id = 0; m.instr_id = NOP;
      m.valid = 0; m.mis = 0; m.cnt = 0;
    end else if (rd) begin
      if (rpc % 4 != 0) m.mis = 1;
      m.pc_id = m.pc_if; m.instr_id = NOP; m.valid = 0;
      m.pc_if = rpc - (rpc % 4);
    end else if (f) begin
      m.pc_id = m.pc_if; m.instr_id = NOP; m.valid = 0;
      if (!s) m.pc_if = m.pc_if + 4;
    end else if (!s) begin
      m.pc_id = m.pc_if; m.instr_id = m.pc_if ^ PATTERN; m.valid = 1;
      m.cnt = m.cnt + 1;
      m.pc_if = m.pc_if + 4;
    end
    exp_q.push_back(m);
    n_pushed++;
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0);
  endtask

  // Monitor: each edge delivers one response, compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_popped++;
        check("pc_IF",         pc_IF,              e.pc_if);
        check("imem_addr_o",   imem_addr_o,        e.pc_if);
        check("instr_IF",      instr_IF,           e.pc_if ^ PATTERN);
        check("pc_ID",         pc_ID,              e.pc_id);
        check("instr_ID",      instr_ID,           e.instr_id);
        check("valid_ID",      {31'h0, valid_ID},  {31'h0, e.valid});
        check("misaligned_o",  {31'h0, misaligned_o}, {31'h0, e.mis});
        check("fetch_count_o", fetch_count_o,      e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    if (!done) begin
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    m = '{pc_if: 32'h0, pc_id: 32'h0, instr_id: 32'h0, valid: 1'b0, mis: 1'b0, cnt: 32'h0};

    // Reset then three free-running fetches.
    step(1, 0, 0, 0, 32'h0);
    adv(3);

    // Stall at pc 8 for two cycles, then resume.
    step(1, 0, 0, 0, 32'h0);
    adv(2);
    step(0, 1, 0, 0, 32'hDEAD_BEEF);
    step(0, 1, 0, 0, 32'h0);
    adv(2);

    // Redirect overriding stall and flush at pc 0x10.
    step(0, 1, 1, 1, 32'h0000_0040);
    adv(1);

    // Misaligned redirect is sticky across later aligned redirects.
    step(0, 0, 0, 1, 32'h0000_0046);
    adv(1);
    step(0, 0, 0, 1, 32'h0000_0100);
    step(0, 0, 1, 0, 32'h0);
    step(0, 1, 1, 0, 32'h0);

    // Address wrap at the top of memory.
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    adv(2);

    // Reset during a stall at pc 0x78.
    step(0, 0, 0, 1, 32'h0000_0078);
    step(0, 1, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    adv(2);

    // Randomized control traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          r, s, f, rd;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 63) == 0);
      s   = ($urandom_range(0, 3) == 0);
      f   = ($urandom_range(0, 7) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      rpc = $urandom();
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      step(r, s, f, rd, rpc);
    end

    @(negedge clk);
    rstn = 1'b0; stall_i = 1'b1; flush_i = 1'b0; redirect_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("responses_seen", n_popped, n_pushed);
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

`default_nettype wire
